score_keeper: RTL



---
 rtl/score_keeper_if.sv | 28 ++
 rtl/score_keeper.sv | 135 +++++++++++++
 2 files changed

// File: rtl/score_keeper_if.sv
`default_nettype none
//==[ score_keeper_if | control and score bundle between score_keeper and its neighbours | rev 1.0 ]==
interface score_keeper_if;
  logic       new_game_i;
  logic       frame_end_i;
  logic       miss_left_i;
  logic       miss_right_i;
  logic [5:0] score_player_1_o;
  logic [5:0] score_player_2_o;
  logic       ball_enable_o;
  logic       serve_o;
  logic       serve_dir_o;
  logic       game_over_o;
  logic       winner_o;

  modport slave (
    input  new_game_i, frame_end_i, miss_left_i, miss_right_i,
    output score_player_1_o, score_player_2_o, ball_enable_o,
    output serve_o, serve_dir_o, game_over_o, winner_o
  );

  modport master (
    output new_game_i, frame_end_i, miss_left_i, miss_right_i,
    input  score_player_1_o, score_player_2_o, ball_enable_o,
    input  serve_o, serve_dir_o, game_over_o, winner_o
  );
endinterface
`default_nettype wire

// File: rtl/score_keeper.sv
`default_nettype none
//==[ score_keeper | pong match scoring: serve delay, rally, point award, game over | rev 1.0 ]==
module score_keeper #(
  parameter int unsigned WIN_SCORE          = 11,
  parameter int unsigned SERVE_DELAY_FRAMES = 60
) (
  input  logic          clk_i,
  input  logic          rst_i,
  score_keeper_if.slave bus
);

  localparam logic [5:0] c_win_score   = 6'(WIN_SCORE);
  localparam logic [7:0] c_serve_delay = 8'(SERVE_DELAY_FRAMES);

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    SERVE_WAIT = 2'd1,
    PLAY       = 2'd2,
    GAME_OVER  = 2'd3
  } state_t;

  state_t     state_q, state_d;
  logic [5:0] score_p1_q, score_p1_d;
  logic [5:0] score_p2_q, score_p2_d;
  logic [7:0] delay_cnt_q, delay_cnt_d;
  logic       miss_left_prev_q, miss_right_prev_q;
  logic       ball_enable_q;
  logic       serve_q, serve_d;
  logic       serve_dir_q, serve_dir_d;
  logic       game_over_q;
  logic       winner_q, winner_d;

  logic       w_left_edge, w_right_edge;
  logic [5:0] w_p1_inc, w_p2_inc;

  assign w_left_edge  = bus.miss_left_i  & ~miss_left_prev_q;
  assign w_right_edge = bus.miss_right_i & ~miss_right_prev_q;
  assign w_p1_inc     = score_p1_q + 6'd1;
  assign w_p2_inc     = score_p2_q + 6'd1;

  always_comb begin
    state_d     = state_q;
    score_p1_d  = score_p1_q;
    score_p2_d  = score_p2_q;
    delay_cnt_d = delay_cnt_q;
    serve_d     = 1'b0;
    serve_dir_d = serve_dir_q;
    winner_d    = winner_q;

    // A restart request wins over anything else happening this cycle.
    if (bus.new_game_i) begin
      state_d     = SERVE_WAIT;
      score_p1_d  = '0;
      score_p2_d  = '0;
      delay_cnt_d = '0;
      serve_dir_d = 1'b0;
      winner_d    = 1'b0;
    end else begin
      case (state_q)
        SERVE_WAIT: begin
          if (delay_cnt_q == c_serve_delay) begin
            serve_d     = 1'b1;
            delay_cnt_d = '0;
            state_d     = PLAY;
          end else if (bus.frame_end_i) begin
            delay_cnt_d = delay_cnt_q + 8'd1;
          end
        end
        PLAY: begin
          if (w_left_edge && w_right_edge) begin
            state_d = SERVE_WAIT;
          end else if (w_right_edge) begin
            // Next serve goes toward the player who just lost the point.
            score_p1_d  = w_p1_inc;
            serve_dir_d = 1'b1;
            if (w_p1_inc == c_win_score) begin
              state_d  = GAME_OVER;
              winner_d = 1'b0;
            end else begin
              state_d = SERVE_WAIT;
            end
          end else if (w_left_edge) begin
            score_p2_d  = w_p2_inc;
            serve_dir_d = 1'b0;
            if (w_p2_inc == c_win_score) begin
              state_d  = GAME_OVER;
              winner_d = 1'b1;
            end else begin
              state_d = SERVE_WAIT;
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q           <= IDLE;
      score_p1_q        <= '0;
      score_p2_q        <= '0;
      delay_cnt_q       <= '0;
      miss_left_prev_q  <= 1'b0;
      miss_right_prev_q <= 1'b0;
      ball_enable_q     <= 1'b0;
      serve_q           <= 1'b0;
      serve_dir_q       <= 1'b0;
      game_over_q       <= 1'b0;
      winner_q          <= 1'b0;
    end else begin
      state_q           <= state_d;
      score_p1_q        <= score_p1_d;
      score_p2_q        <= score_p2_d;
      delay_cnt_q       <= delay_cnt_d;
      miss_left_prev_q  <= bus.miss_left_i;
      miss_right_prev_q <= bus.miss_right_i;
      ball_enable_q     <= (state_d == PLAY);
      serve_q           <= serve_d;
      serve_dir_q       <= serve_dir_d;
      game_over_q       <= (state_d == GAME_OVER);
      winner_q          <= winner_d;
    end
  end

  assign bus.score_player_1_o = score_p1_q;
  assign bus.score_player_2_o = score_p2_q;
  assign bus.ball_enable_o    = ball_enable_q;
  assign bus.serve_o          = serve_q;
  assign bus.serve_dir_o      = serve_dir_q;
  assign bus.game_over_o      = game_over_q;
  assign bus.winner_o         = winner_q;

endmodule
`default_nettype wire
